// File: rtl/ps2_led_bank.sv
// ps2_led_bank
//   Bank of keyboard-driven LED channels fed by a PS/2 byte receiver.
//   A shared prefix decoder tracks E0 (extended) and F0 (break) prefixes.
//   Each channel watches for its own make code. It must see the key held
//   for HOLD_TICKS tick_300k pulses before it toggles its LED (toggle
//   mode) or lights it until release (momentary mode).
//
// Ports
//   clk_2            in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   tick_300k        in   hold-time count enable, synchronous to clk_2
//   code_new_updated in   one-cycle strobe qualifying check_code
//   check_code       in   received scan-code byte
//   leds             out  LED drive, one bit per channel
//   led_changed      out  one-cycle pulse, one edge after a leds bit changes
//   dbg_state        out  per-channel FSM state, 2 bits per channel
//                         (00 idle, 01 hold, 10 wait-release)
//
// Handshake: code_new_updated is a strobe with no backpressure; the byte on
// check_code is consumed on every clock edge where the strobe is high, so
// back-to-back strobes are accepted.
module ps2_led_bank #(
    parameter int                N_CH       = 3,
    parameter logic [8*N_CH-1:0] KEY_CODES  = {8'h7E, 8'h77, 8'h58},
    parameter logic [N_CH-1:0]   MODE       = 3'b000,
    parameter int                HOLD_TICKS = 151
) (
    input  logic                clk_2,
    input  logic                rst_n,
    input  logic                tick_300k,
    input  logic                code_new_updated,
    input  logic [7:0]          check_code,
    output logic [N_CH-1:0]     leds,
    output logic [N_CH-1:0]     led_changed,
    output logic [2*N_CH-1:0]   dbg_state
);

    localparam int             CW   = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0]  LAST = CW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HOLD = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t          r_state [N_CH];
    state_t          w_next  [N_CH];
    logic [CW-1:0]   r_cnt   [N_CH];
    logic            r_ext_pend;
    logic            r_brk_pend;
    logic [N_CH-1:0] r_leds_d;

    logic            w_is_e0;
    logic            w_is_f0;
    logic            w_key_byte;
    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] w_rel;
    logic [N_CH-1:0] w_act;
    logic [N_CH-1:0] w_clr;

    // ---------------- shared prefix decoder ----------------
    assign w_is_e0    = (check_code == 8'hE0);
    assign w_is_f0    = (check_code == 8'hF0);
    assign w_key_byte = code_new_updated && !w_is_e0 && !w_is_f0;

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (code_new_updated) begin
            if (w_is_e0) begin
                r_ext_pend <= 1'b1;
            end else if (w_is_f0) begin
                r_brk_pend <= 1'b1;
            end else begin
                // key byte consumes both prefixes
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    // Key events; extended keys never match any channel.
    always_comb begin
        w_press = '0;
        w_rel   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_key_byte && !r_ext_pend && (check_code == KEY_CODES[8*i +: 8])) begin
                w_press[i] = !r_brk_pend;
                w_rel[i]   = r_brk_pend;
            end
        end
    end

    // ---------------- per-channel FSM: state register ----------------
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= S_IDLE;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_next[i];
            end
        end
    end

    // ---------------- per-channel FSM: next state ----------------
    // A release on the activating tick wins: HOLD tests release first.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_next[i] = r_state[i];
            case (r_state[i])
                S_IDLE: if (w_press[i]) w_next[i] = S_HOLD;
                S_HOLD: begin
                    if (w_rel[i]) begin
                        w_next[i] = S_IDLE;
                    end else if (tick_300k && (r_cnt[i] == LAST)) begin
                        w_next[i] = S_WAIT;
                    end
                end
                S_WAIT: if (w_rel[i]) w_next[i] = S_IDLE;
                default: w_next[i] = S_IDLE;
            endcase
        end
    end

    // ---------------- per-channel FSM: outputs ----------------
    always_comb begin
        w_act     = '0;
        w_clr     = '0;
        dbg_state = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_act[i] = (r_state[i] == S_HOLD) && tick_300k && !w_rel[i]
                       && (r_cnt[i] == LAST);
            w_clr[i] = (r_state[i] == S_WAIT) && w_rel[i] && MODE[i];
            dbg_state[2*i +: 2] = r_state[i];
        end
    end

    // Hold counter: cleared on press, advanced by ticks while holding.
    // The activating tick leaves HOLD, so the count never exceeds HOLD_TICKS.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if ((r_state[i] == S_IDLE) && w_press[i]) begin
                    r_cnt[i] <= '0;
                end else if ((r_state[i] == S_HOLD) && tick_300k && !w_rel[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // LED drive and change pulse (one edge after the LED moves).
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            leds        <= '0;
            r_leds_d    <= '0;
            led_changed <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_act[i]) begin
                    leds[i] <= MODE[i] ? 1'b1 : ~leds[i];
                end else if (w_clr[i]) begin
                    leds[i] <= 1'b0;
                end
            end
            r_leds_d    <= leds;
            led_changed <= leds ^ r_leds_d;
        end
    end

endmodule

// File: tb/tb_ps2_led_bank.sv
// Self-checking bench for ps2_led_bank.
//   dut_a: HOLD_TICKS=4, ch1 momentary, tick tied high (fast directed cases)
//   dut_b: HOLD_TICKS=151, all toggle, tick every 7th cycle (short press)
// Inputs are driven and outputs sampled on the falling edge.
module tb_ps2_led_bank;

    logic       clk_2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_a = 1'b1;
    logic       tick_b = 1'b0;
    logic       strobe_a = 1'b0;
    logic       strobe_b = 1'b0;
    logic [7:0] check_code = 8'h00;

    logic [2:0] leds_a, chg_a, leds_b, chg_b;
    logic [5:0] dbg_a, dbg_b;

    int vectors = 0;
    int fails   = 0;
    logic [7:0] exp_q[$];

    int pulses_a[3];
    int pulses_b = 0;
    int tick_div = 0;
    int base;

    // ---------------- clock / reset / tick ----------------
    always #5 clk_2 = ~clk_2;

    always @(negedge clk_2) begin
        tick_div = (tick_div == 6) ? 0 : tick_div + 1;
        tick_b   = (tick_div == 0);
    end

    // led_changed pulse counters
    initial begin
        for (int i = 0; i < 3; i++) pulses_a[i] = 0;
    end
    always @(negedge clk_2) begin
        for (int i = 0; i < 3; i++) if (chg_a[i]) pulses_a[i]++;
        if (chg_b != 3'b000) pulses_b++;
    end

    ps2_led_bank #(
        .N_CH(3), .KEY_CODES({8'h7E, 8'h77, 8'h58}), .MODE(3'b010), .HOLD_TICKS(4)
    ) dut_a (
        .clk_2(clk_2), .rst_n(rst_n), .tick_300k(tick_a),
        .code_new_updated(strobe_a), .check_code(check_code),
        .leds(leds_a), .led_changed(chg_a), .dbg_state(dbg_a)
    );

    ps2_led_bank #(
        .N_CH(3), .KEY_CODES({8'h7E, 8'h77, 8'h58}), .MODE(3'b000), .HOLD_TICKS(151)
    ) dut_b (
        .clk_2(clk_2), .rst_n(rst_n), .tick_300k(tick_b),
        .code_new_updated(strobe_b), .check_code(check_code),
        .leds(leds_b), .led_changed(chg_b), .dbg_state(dbg_b)
    );

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send_a(input logic [7:0] c);
        check_code = c;
        strobe_a   = 1'b1;
        @(negedge clk_2);
        strobe_a   = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] c);
        check_code = c;
        strobe_b   = 1'b1;
        @(negedge clk_2);
        strobe_b   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [7:0] obs);
        if (exp_q.size() == 0) begin
            vectors++;
            fails++;
            $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle(2);
        check("rst_leds_a", {5'd0, leds_a}, 8'h00);
        check("rst_chg_a", {5'd0, chg_a}, 8'h00);
        check("rst_leds_b", {5'd0, leds_b}, 8'h00);
        check("rst_dbg_a", {2'd0, dbg_a}, 8'h00);
        rst_n = 1'b1;
        idle(2);

        // toggle basic: LED rises 4 edges after the press
        base = pulses_a[0];
        send_a(8'h58);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        check("t1_hold_state", {6'd0, dbg_a[1:0]}, 8'h01);
        idle(3);
        check_q("t1_before_act", {5'd0, leds_a});
        idle(1);
        check_q("t1_act", {5'd0, leds_a});
        idle(1);
        check("t1_chg_pulse", {5'd0, chg_a}, 8'h01);
        idle(1);
        check("t1_chg_gone", {5'd0, chg_a}, 8'h00);
        idle(4);
        send_a(8'hF0);
        send_a(8'h58);
        exp_q.push_back(8'h01);
        idle(2);
        check_q("t1_after_rel", {5'd0, leds_a});
        check("t1_idle_state", {6'd0, dbg_a[1:0]}, 8'h00);
        send_a(8'h58);
        exp_q.push_back(8'h00);
        idle(4);
        check_q("t1_second_toggle", {5'd0, leds_a});
        send_a(8'hF0);
        send_a(8'h58);
        idle(2);
        check("t1_pulse_count", 8'(pulses_a[0] - base), 8'd2);

        // typematic: repeats while held give one toggle only
        base = pulses_a[0];
        send_a(8'h58);
        repeat (10) send_a(8'h58);
        send_a(8'hF0);
        send_a(8'h58);
        exp_q.push_back(8'h01);
        idle(3);
        check_q("typ_leds", {5'd0, leds_a});
        check("typ_pulse_count", 8'(pulses_a[0] - base), 8'd1);

        // release on the activating tick wins: no toggle
        base = pulses_a[0];
        send_a(8'h58);
        idle(2);
        send_a(8'hF0);
        send_a(8'h58);
        exp_q.push_back(8'h01);
        idle(3);
        check_q("race_leds", {5'd0, leds_a});
        check("race_state", {6'd0, dbg_a[1:0]}, 8'h00);
        check("race_pulses", 8'(pulses_a[0] - base), 8'd0);

        // momentary on ch1
        base = pulses_a[1];
        send_a(8'h77);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h01);
        idle(3);
        check_q("mom_before", {5'd0, leds_a});
        idle(1);
        check_q("mom_on", {5'd0, leds_a});
        idle(2);
        check_q("mom_held", {5'd0, leds_a});
        send_a(8'hF0);
        check_q("mom_after_f0", {5'd0, leds_a});
        send_a(8'h77);
        check_q("mom_released", {5'd0, leds_a});
        idle(2);
        check("mom_pulses", 8'(pulses_a[1] - base), 8'd2);

        // extended prefix: no channel reacts
        send_a(8'hE0);
        send_a(8'h7E);
        idle(6);
        check("ext_make_leds", {5'd0, leds_a}, 8'h01);
        check("ext_make_state", {6'd0, dbg_a[5:4]}, 8'h00);
        send_a(8'hE0);
        send_a(8'hF0);
        send_a(8'h7E);
        idle(6);
        check("ext_break_leds", {5'd0, leds_a}, 8'h01);
        send_a(8'h7E);
        check("ext_cleared_arm", {6'd0, dbg_a[5:4]}, 8'h01);
        idle(4);
        check("ext_plain_act", {5'd0, leds_a}, 8'h05);
        send_a(8'hF0);
        send_a(8'h7E);
        idle(2);
        check("ext_plain_rel", {5'd0, leds_a}, 8'h05);

        // reset two ticks into HOLD
        send_a(8'h58);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_leds", {5'd0, leds_a}, 8'h00);
        check("rst_async_state", {2'd0, dbg_a}, 8'h00);
        @(negedge clk_2);
        rst_n = 1'b1;
        base = pulses_a[0];
        send_a(8'hF0);
        send_a(8'h58);
        idle(6);
        check("rst_orphan_rel", {5'd0, leds_a}, 8'h00);
        check("rst_orphan_pulses", 8'(pulses_a[0] - base), 8'd0);
        send_a(8'h58);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        idle(3);
        check_q("rst_fresh_early", {5'd0, leds_a});
        idle(1);
        check_q("rst_fresh_act", {5'd0, leds_a});
        send_a(8'hF0);
        send_a(8'h58);

        // short press on dut_b: ~100 ticks of a 151-tick hold
        base = pulses_b;
        send_b(8'h58);
        idle(700);
        check("short_still_hold", {6'd0, dbg_b[1:0]}, 8'h01);
        send_b(8'hF0);
        send_b(8'h58);
        exp_q.push_back(8'h00);
        idle(3);
        check_q("short_leds", {5'd0, leds_b});
        check("short_pulses", 8'(pulses_b - base), 8'd0);

        // long press on dut_b: 151 ticks is enough
        send_b(8'h58);
        exp_q.push_back(8'h01);
        idle(1100);
        check_q("long_leds", {5'd0, leds_b});
        send_b(8'hF0);
        send_b(8'h58);
        idle(3);
        check("long_pulses", 8'(pulses_b - base), 8'd1);

        if (exp_q.size() != 0) begin
            vectors++;
            fails++;
            $error("FAIL leftover_expect observed=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/ps2_led_bank.md
# ps2_led_bank

Parametrised bank of keyboard-driven LED channels, the successor to the single Caps Lock LED toggler. It sits after the PS/2 byte receiver. Each channel watches the received scan-code stream for its own key and drives one LED in either toggle or momentary mode. A hold-time qualifier measured in ticks of the 300 kHz enable rejects short presses, and make/break decoding is full: F0 break prefix, E0 extended prefix, and typematic repeats ignored.

## Interface
Parameters:
- N_CH, 3: number of LED channels (1..8).
- KEY_CODES, {8'h7E, 8'h77, 8'h58}: N_CH packed 8-bit make codes. Channel i uses bits [8i+7:8i]. Defaults: ch0 Caps, ch1 Num, ch2 Scroll.
- MODE, 3'b000: per-channel mode bit. 0 = toggle, 1 = momentary.
- HOLD_TICKS, 151: tick_300k pulses a key must be held before the channel acts. Must be ≥1.

Ports:
- clk_2  in  1: system clock; all logic on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- tick_300k  in  1: clock enable, synchronous to clk_2; counts hold time.
- code_new_updated  in  1: one-cycle strobe; check_code is valid in the same cycle.
- check_code  in  8: received scan-code byte.
- leds  out  N_CH: LED drive, one bit per channel.
- led_changed  out  N_CH: one-cycle pulse on the cycle after the corresponding leds bit changes.

## Operation
- Prefix decoder (shared), updated only on code_new_updated:
  - 8'hE0 sets ext_pend.
  - 8'hF0 sets brk_pend; ext_pend is kept.
  - Any other byte is a key byte. It is classified with the pending flags, then both flags clear.
- Key byte classification:
  - ext_pend=1: matches no channel, for both press and release.
  - brk_pend=1: release event for every channel whose code equals the byte.
  - Otherwise: press event for every channel whose code equals the byte.
- Several channels with the same code act in lockstep.
- Per-channel FSM:
  - IDLE: on press, go to HOLD and clear cnt.
  - HOLD: cnt increments on each tick_300k. A release returns the channel to IDLE with no LED change.
    - The tick that brings the count to HOLD_TICKS is the activating tick.
    - On that edge, toggle mode inverts the LED and momentary mode sets it to 1. The FSM moves to WAIT_REL.
  - WAIT_REL: repeated presses (typematic) are ignored.
    - On release, go to IDLE.
    - In momentary mode the LED also clears to 0 on the same edge.
- cnt width is clog2(HOLD_TICKS+1) bits. cnt never wraps; it is only meaningful in HOLD.
- Release in the same cycle as the activating tick: the release wins. No activation occurs and the FSM goes to IDLE.
- Prefix bytes (E0, F0) never affect channel FSMs. Ticks outside HOLD are ignored.
- led_changed[i] is the registered XOR of leds[i] with its previous value.
- Reset (rst_n low, at any time, including mid-HOLD):
  - leds = 0 and led_changed = 0.
  - All FSMs return to IDLE; cnt = 0; ext_pend = brk_pend = 0.
  - Outputs change immediately, without waiting for a clock edge.

## Timing
- Press strobe at edge t: the channel is in HOLD after edge t. Ticks sampled from edge t+1 onward count.
- Minimum activation: HOLD_TICKS cycles with tick_300k held high. The LED changes at edge t+HOLD_TICKS.
- led_changed pulses for exactly one cycle, one edge after the leds change.
- Release strobe at edge r: the state is IDLE after edge r. A momentary LED is 0 after edge r.
- Back-to-back strobes on consecutive cycles are supported. There is no input backpressure.

## Test plan
- Toggle basic (HOLD_TICKS=4, tick tied high):
  - Stimulus: 58, then F0 58 after 10 cycles.
  - Required: leds[0] rises 4 cycles after the 58 strobe, led_changed[0] pulses once, leds[0] stays 1 after release.
  - Repeat the sequence: leds[0] returns to 0.
- Short press (HOLD_TICKS=151, tick every 7th cycle):
  - Stimulus: 58, then F0 58 after 100 ticks.
  - Required: leds stays 0 and led_changed stays 0.
- Typematic (HOLD_TICKS=4):
  - Stimulus: 58 followed by ten more 58 strobes, then F0 58.
  - Required: exactly one toggle.
- Momentary (MODE=3'b010):
  - Stimulus: 77, held 6 ticks, then F0 77.
  - Required: leds[1] is 1 during the hold after the 4th tick and 0 on the F0 77 edge.
- Extended/prefix:
  - Stimulus: E0 7E, and E0 F0 7E.
  - Required: no channel reacts; ext_pend is cleared afterwards, so a following plain 7E arms ch2.
- Reset mid-HOLD:
  - Stimulus: assert rst_n low between clock edges, 2 ticks into HOLD.
  - Required: leds = 0 immediately.
  - After release of reset, F0 58 alone causes no change.
  - A fresh 58 press needs the full HOLD_TICKS.
